// File: rtl/vblank_update_sched_pkg.sv
// Shared definitions for the vblank update scheduler: FSM state encodings,
// the "no pixel requested" row sentinel and the parameter defaults.
package vblank_update_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } sched_state_e;

  // pix_y carries this value whenever the timing controller is outside the
  // active pixel-request region, i.e. during blanking.
  localparam logic [9:0] PIX_NONE = 10'h3FF;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_FRAME_DIV   = 1;

endpackage

// File: rtl/sched_timeout_cnt.sv
// Per-slot grant timer.
//   i_clk/i_rst_n : clock, async active-low reset
//   i_clr         : synchronous clear (asserted while a grant is being issued)
//   i_en          : count enable (asserted while waiting for completion)
//   o_expire      : high while enabled and the count sits at TIMEOUT_CYC-1
module sched_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == TW'(TIMEOUT_CYC - 1));
  assign o_expire = i_en && w_at_max;

  // Holds at the terminal count rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_cnt <= '0;
    else if (i_clr)             r_cnt <= '0;
    else if (i_en && !w_at_max) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/vblank_update_sched.sv
// Vertical-blanking update scheduler. Once every FRAME_DIV frames it grants
// N_REQ requesters one at a time (one-hot upd_req) during vblank, each until
// it pulses upd_done or its timer expires. Active pixel rows or a new frame
// arriving mid-sequence abort it and raise the sticky overrun flag.
//   vga_clk, sys_rst_n   : pixel clock, async active-low reset
//   vsync, pix_y, run_en : timing controller inputs and game-run enable
//   upd_done, clr_err    : per-requester completion pulse, error clear pulse
//   upd_req, busy        : one-hot grant, sequence in progress
//   frame_tick, frame_cnt: frame start pulse, 16-bit wrapping frame counter
//   overrun, tmo_err     : sticky sequence-overrun and per-slot timeout flags
module vblank_update_sched
  import vblank_update_sched_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int FRAME_DIV   = DEF_FRAME_DIV
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             vsync,
  input  logic [9:0]       pix_y,
  input  logic             run_en,
  input  logic [N_REQ-1:0] upd_done,
  input  logic             clr_err,
  output logic [N_REQ-1:0] upd_req,
  output logic             busy,
  output logic             frame_tick,
  output logic [15:0]      frame_cnt,
  output logic             overrun,
  output logic [N_REQ-1:0] tmo_err
);

  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  sched_state_e     r_state, w_nxt_state;
  logic [SW-1:0]    r_slot, w_nxt_slot;
  logic [N_REQ-1:0] r_upd_req, w_nxt_req;
  logic             r_vsync_q, r_frame_tick, r_overrun;
  logic [15:0]      r_frame_cnt;
  logic [DW-1:0]    r_div;
  logic [N_REQ-1:0] r_tmo_err, w_set_tmo;
  logic             w_set_ovr, w_fs, w_launch, w_busy, w_done, w_expire;

  assign w_fs     = vsync & ~r_vsync_q;
  // Launch decisions use the registered frame pulse, which puts the first
  // grant two cycles after the vsync edge is sampled.
  assign w_launch = r_frame_tick && (r_div == '0) && run_en;
  assign w_busy   = (r_state != S_IDLE);
  assign w_done   = upd_done[r_slot];

  sched_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .i_clk   (vga_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (r_state == S_GRANT),
    .i_en    (r_state == S_WAIT),
    .o_expire(w_expire)
  );

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vsync_q    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
      r_div        <= '0;
    end else begin
      r_vsync_q    <= vsync;
      r_frame_tick <= w_fs;
      if (r_frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_div       <= (r_div == DW'(FRAME_DIV - 1)) ? '0 : r_div + 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_req   = r_upd_req;
    w_set_ovr   = 1'b0;
    w_set_tmo   = '0;
    unique case (r_state)
      S_IDLE: if (w_launch) begin
        w_nxt_state = S_GRANT;
        w_nxt_slot  = '0;
      end
      S_GRANT: begin
        w_nxt_req   = N_REQ'(1) << r_slot;
        w_nxt_state = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a coinciding timeout: no error in that case.
        if (w_done) begin
          w_nxt_state = S_NEXT;
        end else if (w_expire) begin
          w_nxt_state       = S_NEXT;
          w_set_tmo[r_slot] = 1'b1;
        end
      end
      S_NEXT: begin
        w_nxt_req = '0;
        if (r_slot == SW'(N_REQ - 1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_slot  = '0;
        end else begin
          w_nxt_state = S_GRANT;
          w_nxt_slot  = r_slot + 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // A new frame while busy restarts from slot 0 (if allowed to launch);
    // visible pixels while busy abandon the sequence. Either drops the grant.
    if (w_busy && r_frame_tick) begin
      w_set_ovr   = 1'b1;
      w_nxt_req   = '0;
      w_nxt_slot  = '0;
      w_nxt_state = w_launch ? S_GRANT : S_IDLE;
    end else if (w_busy && (pix_y != PIX_NONE)) begin
      w_set_ovr   = 1'b1;
      w_nxt_req   = '0;
      w_nxt_slot  = '0;
      w_nxt_state = S_IDLE;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_upd_req <= '0;
      r_overrun <= 1'b0;
      r_tmo_err <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_slot    <= w_nxt_slot;
      r_upd_req <= w_nxt_req;
      // A flag being set in the same cycle as clr_err stays set.
      r_overrun <= w_set_ovr | (r_overrun & ~clr_err);
      r_tmo_err <= w_set_tmo | (r_tmo_err & {N_REQ{~clr_err}});
    end
  end

  assign upd_req    = r_upd_req;
  assign busy       = w_busy;
  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
  assign overrun    = r_overrun;
  assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_vblank_update_sched.sv
// Directed bench: dut1 (FRAME_DIV=1) covers sequencing, timeout, abort,
// done/timeout race, clear-vs-set and reset; dut2 (FRAME_DIV=2) covers the
// frame divider, run_en gating and frame counter wrap. Expected grants are
// queued as {instance,slot} codes and popped by a monitor on each new grant.
module tb_vblank_update_sched;

  logic        clk = 1'b0;
  logic        rst_n, vsync1, vsync2, run_en1, run_en2, clr_err;
  logic [9:0]  pix_y;
  logic [3:0]  upd_done;
  logic [3:0]  req1, req2, tmo1, tmo2;
  logic        busy1, busy2, ftick1, ftick2, ovr1, ovr2;
  logic [15:0] fcnt1, fcnt2;

  int checks = 0;
  int fails  = 0;
  int exp_q[$];
  int resp_dly[4];

  always #5 clk = ~clk;

  vblank_update_sched #(.N_REQ(4), .TIMEOUT_CYC(16), .FRAME_DIV(1)) dut1 (
    .vga_clk(clk), .sys_rst_n(rst_n), .vsync(vsync1), .pix_y(pix_y),
    .run_en(run_en1), .upd_done(upd_done), .clr_err(clr_err),
    .upd_req(req1), .busy(busy1), .frame_tick(ftick1), .frame_cnt(fcnt1),
    .overrun(ovr1), .tmo_err(tmo1));

  vblank_update_sched #(.N_REQ(4), .TIMEOUT_CYC(16), .FRAME_DIV(2)) dut2 (
    .vga_clk(clk), .sys_rst_n(rst_n), .vsync(vsync2), .pix_y(pix_y),
    .run_en(run_en2), .upd_done(upd_done), .clr_err(clr_err),
    .upd_req(req2), .busy(busy2), .frame_tick(ftick2), .frame_cnt(fcnt2),
    .overrun(ovr2), .tmo_err(tmo2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic sb_pop(input int code);
    if (exp_q.size() == 0) chk("sb_extra_grant", 32'(code), 32'hFFFF_FFFF);
    else chk("sb_grant_order", 32'(code), 32'(exp_q.pop_front()));
  endtask

  task automatic push_seq(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + i);
  endtask

  // Responder: pulses upd_done for the granted slot resp_dly cycles after the
  // grant is first seen (age 0 falls in the first WAIT cycle, timer=0).
  initial begin : responder
    logic [3:0] prev, cur;
    int age;
    prev = '0; age = 0; upd_done = '0;
    forever begin
      @(negedge clk);
      cur = req1 | req2;
      if (cur != '0 && cur == prev) age++; else age = 0;
      prev = cur;
      upd_done = '0;
      if (cur != '0 && resp_dly[slot_of(cur)] == age) upd_done = cur;
    end
  end

  initial begin : monitor
    logic [3:0] p1, p2, r;
    p1 = '0; p2 = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("onehot1", 32'($onehot0(req1)), 32'd1);
        chk("onehot2", 32'($onehot0(req2)), 32'd1);
        r = req1 & ~p1; if (r != '0) sb_pop(slot_of(r));
        r = req2 & ~p2; if (r != '0) sb_pop(16 + slot_of(r));
      end
      p1 = req1; p2 = req2;
    end
  end

  // vsync pulse on dut1 with frame_tick and first-grant latency checks.
  task automatic frame1(input int tail);
    @(negedge clk); vsync1 = 1'b1;
    @(negedge clk); vsync1 = 1'b0;
    chk("ftick_hi", 32'(ftick1), 32'd1);
    chk("req_lat0", 32'(req1), 32'd0);
    @(negedge clk);
    chk("ftick_lo", 32'(ftick1), 32'd0);
    chk("busy_grant", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("req_lat2", 32'(req1), 32'd1);
    repeat (tail) @(negedge clk);
  endtask

  task automatic frame2(input int tail);
    @(negedge clk); vsync2 = 1'b1;
    @(negedge clk); vsync2 = 1'b0;
    repeat (tail) @(negedge clk);
  endtask

  task automatic wait_req(input int s);
    int n = 0;
    while (!req1[s] && n < 100) begin @(negedge clk); n++; end
    chk("wait_req", 32'(req1[s]), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int len;
    rst_n = 1'b1; vsync1 = 0; vsync2 = 0; run_en1 = 0; run_en2 = 0;
    clr_err = 0; pix_y = 10'h3FF;
    for (int i = 0; i < 4; i++) resp_dly[i] = 5;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_ftick", 32'(ftick1), 32'd0);
    chk("rst_fcnt", 32'(fcnt1), 32'd0);
    chk("rst_ovr", 32'(ovr1), 32'd0);
    chk("rst_tmo", 32'(tmo1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three normal frames, done 5 cycles after each grant.
    run_en1 = 1'b1;
    repeat (3) begin push_seq(0, 4); frame1(45); end
    chk("t1_fcnt", 32'(fcnt1), 32'd3);
    chk("t1_ovr", 32'(ovr1), 32'd0);
    chk("t1_tmo", 32'(tmo1), 32'd0);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // Slot 2 silent: held through 16 WAIT cycles plus the NEXT cycle.
    resp_dly[2] = -1;
    push_seq(0, 4); frame1(0);
    wait_req(2);
    len = 0;
    while (req1[2] && len < 40) begin len++; @(negedge clk); end
    chk("t2_hold_len", 32'(len), 32'd17);
    repeat (30) @(negedge clk);
    chk("t2_tmo", 32'(tmo1), 32'b0100);
    chk("t2_ovr", 32'(ovr1), 32'd0);
    chk("t2_idle", 32'(busy1), 32'd0);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    chk("t2_clr", 32'(tmo1), 32'd0);
    resp_dly[2] = 5;

    // Visible row while slot 1 is granted.
    push_seq(0, 2); frame1(0);
    wait_req(1);
    pix_y = 10'd0;
    @(negedge clk);
    pix_y = 10'h3FF;
    chk("t3_req", 32'(req1), 32'd0);
    chk("t3_ovr", 32'(ovr1), 32'd1);
    chk("t3_busy", 32'(busy1), 32'd0);
    repeat (20) @(negedge clk);
    chk("t3_stay_idle", 32'(busy1), 32'd0);
    pulse_clr();
    chk("t3_clr", 32'(ovr1), 32'd0);

    // Slot 1 done coincides with its timeout; slot 3 times out as clr_err pulses.
    resp_dly[1] = 15; resp_dly[3] = -1;
    push_seq(0, 4); frame1(0);
    wait_req(3);
    chk("t4_done_wins", 32'(tmo1), 32'd0);
    repeat (15) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_set_beats_clr", 32'(tmo1), 32'b1000);
    repeat (10) @(negedge clk);
    chk("t4_idle", 32'(busy1), 32'd0);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);
    pulse_clr();
    resp_dly[1] = 5; resp_dly[3] = 5;

    // Reset during slot 2.
    push_seq(0, 3); frame1(0);
    wait_req(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req", 32'(req1), 32'd0);
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_ftick", 32'(ftick1), 32'd0);
    chk("t5_fcnt", 32'(fcnt1), 32'd0);
    chk("t5_ovr", 32'(ovr1), 32'd0);
    chk("t5_tmo", 32'(tmo1), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    push_seq(0, 4); frame1(45);
    chk("t5_fcnt_after", 32'(fcnt1), 32'd1);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // Divider and wrap on dut2: frames 0-1 gated, frame 2 runs, frame 3 skipped.
    run_en1 = 1'b0;
    force dut2.r_frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut2.r_frame_cnt;
    frame2(10);
    chk("t6_fcnt_ffff", 32'(fcnt2), 32'h0000_FFFF);
    frame2(10);
    chk("t6_fcnt_wrap", 32'(fcnt2), 32'd0);
    run_en2 = 1'b1;
    push_seq(16, 4); frame2(45);
    chk("t6_fcnt_f2", 32'(fcnt2), 32'd1);
    chk("t6_drain_f2", 32'(exp_q.size()), 32'd0);
    frame2(45);
    chk("t6_fcnt_f3", 32'(fcnt2), 32'd2);
    chk("t6_busy", 32'(busy2), 32'd0);
    chk("t6_ovr", 32'(ovr2), 32'd0);
    chk("t6_tmo", 32'(tmo2), 32'd0);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
